// File: rtl/core_run_ctrl.sv
// Run controller for the single-cycle core: gates core_en, sequences halt/run/step/core-reset
// commands, stops on a PC breakpoint and keeps a saturating retired-instruction count.
module core_run_ctrl #(
    parameter int PC_W       = 8,
    parameter int RST_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    // Command handshake: a command transfers on any cycle where cmd_valid && cmd_ready.
    input  logic            cmd_valid,
    input  logic [1:0]      cmd,
    output logic            cmd_ready,
    input  logic            bp_en,
    input  logic [PC_W-1:0] bp_addr,
    input  logic [PC_W-1:0] pc,
    output logic            core_en,
    output logic            core_rst,
    output logic            halted,
    output logic [1:0]      halt_cause,
    output logic            step_done,
    output logic [31:0]     retired,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2,
        S_CRST = 2'd3
    } state_t;

    localparam logic [1:0] CMD_HALT  = 2'b00;
    localparam logic [1:0] CMD_RUN   = 2'b01;
    localparam logic [1:0] CMD_STEP  = 2'b10;
    localparam logic [1:0] CMD_RESET = 2'b11;

    localparam logic [1:0] CAUSE_RESET = 2'b00;
    localparam logic [1:0] CAUSE_CMD   = 2'b01;
    localparam logic [1:0] CAUSE_BP    = 2'b10;
    localparam logic [1:0] CAUSE_STEP  = 2'b11;

    localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RST_CYCLES - 1);

    state_t           state_q, state_d;
    logic [1:0]       cause_q, cause_d;
    logic             skip_q, skip_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step_done_q;
    logic [31:0]      retired_q;
    logic             bp_hit;
    logic             accept;
    logic             crst_entry;

    // skip lets a resumed RUN execute the breakpointed instruction once.
    assign bp_hit    = bp_en && (pc == bp_addr) && !skip_q;
    assign cmd_ready = !rst && ((state_q == S_HALT) || (state_q == S_RUN));
    assign accept    = cmd_valid && cmd_ready;
    assign core_en   = !rst && (((state_q == S_RUN) && !bp_hit) || (state_q == S_STEP));
    assign core_rst  = rst || (state_q == S_CRST);

    assign halted     = (state_q == S_HALT);
    assign halt_cause = cause_q;
    assign step_done  = step_done_q;
    assign retired    = retired_q;
    assign dbg_state  = state_q;

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        skip_d     = skip_q;
        cnt_d      = cnt_q;
        crst_entry = 1'b0;

        if ((state_q == S_RUN) && core_en) begin
            skip_d = 1'b0;
        end

        case (state_q)
            S_HALT: begin
                if (accept) begin
                    case (cmd)
                        CMD_RUN: begin
                            state_d = S_RUN;
                            skip_d  = 1'b1;
                        end
                        CMD_STEP: state_d = S_STEP;
                        CMD_RESET: begin
                            state_d    = S_CRST;
                            cnt_d      = CNT_LOAD;
                            crst_entry = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                // An accepted command takes priority over a simultaneous breakpoint.
                if (accept && (cmd == CMD_HALT)) begin
                    state_d = S_HALT;
                    cause_d = CAUSE_CMD;
                end else if (accept && (cmd == CMD_RESET)) begin
                    state_d    = S_CRST;
                    cnt_d      = CNT_LOAD;
                    crst_entry = 1'b1;
                end else if (bp_hit) begin
                    state_d = S_HALT;
                    cause_d = CAUSE_BP;
                end
            end
            S_STEP: begin
                state_d = S_HALT;
                cause_d = CAUSE_STEP;
            end
            S_CRST: begin
                if (cnt_q == '0) begin
                    state_d = S_HALT;
                    cause_d = CAUSE_RESET;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_HALT;
            cause_q     <= CAUSE_RESET;
            skip_q      <= 1'b0;
            cnt_q       <= '0;
            step_done_q <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            skip_q      <= skip_d;
            cnt_q       <= cnt_d;
            step_done_q <= (state_q == S_STEP);
            if (crst_entry) begin
                retired_q <= '0;
            end else if (core_en && (retired_q != 32'hFFFF_FFFF)) begin
                retired_q <= retired_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: directed vector table, saturation and mid-run reset sequences,
// then random commands checked against a behavioural model.
module tb_core_run_ctrl;

  localparam int PC_W       = 8;
  localparam int RST_CYCLES = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cmd_valid = 1'b0;
  logic [1:0]      cmd = 2'b00;
  logic            cmd_ready;
  logic            bp_en = 1'b0;
  logic [PC_W-1:0] bp_addr = '0;
  logic [PC_W-1:0] pc = '0;
  logic            core_en;
  logic            core_rst;
  logic            halted;
  logic [1:0]      halt_cause;
  logic            step_done;
  logic [31:0]     retired;
  logic [1:0]      dbg_state;

  int checks = 0;
  int errors = 0;

  core_run_ctrl #(.PC_W(PC_W), .RST_CYCLES(RST_CYCLES)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .core_en(core_en), .core_rst(core_rst),
    .halted(halted), .halt_cause(halt_cause), .step_done(step_done), .retired(retired),
    .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        cv;
    logic [1:0]  c;
    logic        be;
    logic [7:0]  ba;
    logic [7:0]  p;
    logic        en;
    logic        crst;
    logic        h;
    logic [1:0]  cause;
    logic        rdy;
    logic        sd;
    logic [31:0] ret;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, cv, input logic [1:0] c, input logic be,
                     input logic [7:0] ba, p, input logic en, crst, h,
                     input logic [1:0] cause, input logic rdy, sd, input logic [31:0] ret);
    vec_t v;
    v.r = r; v.cv = cv; v.c = c; v.be = be; v.ba = ba; v.p = p;
    v.en = en; v.crst = crst; v.h = h; v.cause = cause; v.rdy = rdy; v.sd = sd; v.ret = ret;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: mode 0 halted, 1 running, 2 single step, 3 resetting core.
  int              m_mode;
  int              m_left;
  bit              m_skip;
  longint unsigned m_ret;
  logic [1:0]      m_cause;
  bit              m_sd;
  logic            x_en, x_crst, x_h, x_rdy;

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_skip = 0; m_ret = 0; m_cause = 2'b00; m_sd = 0;
  endtask

  task automatic model_expect();
    bit bp;
    bp     = bp_en && (pc == bp_addr) && !m_skip;
    x_en   = !rst && ((m_mode == 1 && !bp) || m_mode == 2);
    x_crst = rst || (m_mode == 3);
    x_rdy  = !rst && (m_mode == 0 || m_mode == 1);
    x_h    = (m_mode == 0);
  endtask

  task automatic model_step();
    bit bp;
    bit acc;
    model_expect();
    if (rst) begin
      model_reset();
      return;
    end
    bp   = bp_en && (pc == bp_addr) && !m_skip;
    acc  = cmd_valid && x_rdy;
    m_sd = (m_mode == 2);
    if (x_en && m_ret < 64'hFFFF_FFFF) m_ret = m_ret + 1;
    if (x_en && m_mode == 1) m_skip = 0;
    case (m_mode)
      0: if (acc) begin
        if (cmd == 2'b01) begin m_mode = 1; m_skip = 1; end
        else if (cmd == 2'b10) m_mode = 2;
        else if (cmd == 2'b11) begin m_mode = 3; m_left = RST_CYCLES; m_ret = 0; end
      end
      1: begin
        if (acc && cmd == 2'b00) begin m_mode = 0; m_cause = 2'b01; end
        else if (acc && cmd == 2'b11) begin m_mode = 3; m_left = RST_CYCLES; m_ret = 0; end
        else if (bp) begin m_mode = 0; m_cause = 2'b10; end
      end
      2: begin m_mode = 0; m_cause = 2'b11; end
      default: begin
        m_left = m_left - 1;
        if (m_left == 0) begin m_mode = 0; m_cause = 2'b00; end
      end
    endcase
  endtask

  task automatic check_model(input string tag);
    model_expect();
    chk({tag, " core_en"}, 32'(core_en), 32'(x_en));
    chk({tag, " core_rst"}, 32'(core_rst), 32'(x_crst));
    chk({tag, " cmd_ready"}, 32'(cmd_ready), 32'(x_rdy));
    chk({tag, " halted"}, 32'(halted), 32'(x_h));
    chk({tag, " halt_cause"}, 32'(halt_cause), 32'(m_cause));
    chk({tag, " step_done"}, 32'(step_done), 32'(m_sd));
    chk({tag, " retired"}, retired, m_ret[31:0]);
  endtask

  // driver: called at a negedge, returns at the next negedge
  task automatic cycle(input string tag, input logic r, cv, input logic [1:0] c,
                       input logic be, input logic [7:0] ba, p);
    rst = r; cmd_valid = cv; cmd = c; bp_en = be; bp_addr = ba; pc = p;
    #1;
    check_model(tag);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    //   r cv c  be ba p  | en crst h cause rdy sd ret
    add(1, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 1, 0, 0);
    add(0, 1, 2, 0, 0, 0,   0, 0, 1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 2, 0, 0, 1,   0, 0, 1, 3, 1, 1, 1);
    add(0, 0, 0, 0, 0, 1,   1, 0, 0, 3, 0, 0, 1);
    add(0, 1, 2, 0, 0, 2,   0, 0, 1, 3, 1, 1, 2);
    add(0, 0, 0, 0, 0, 2,   1, 0, 0, 3, 0, 0, 2);
    add(0, 0, 0, 0, 0, 3,   0, 0, 1, 3, 1, 1, 3);
    add(0, 0, 0, 0, 0, 3,   0, 0, 1, 3, 1, 0, 3);
    // breakpoint at pc 5 from a fresh reset
    add(1, 0, 0, 1, 5, 0,   0, 1, 1, 3, 0, 0, 3);
    add(0, 1, 1, 1, 5, 0,   0, 0, 1, 0, 1, 0, 0);
    add(0, 0, 0, 1, 5, 0,   1, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 5, 1,   1, 0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 1, 5, 2,   1, 0, 0, 0, 1, 0, 2);
    add(0, 0, 0, 1, 5, 3,   1, 0, 0, 0, 1, 0, 3);
    add(0, 0, 0, 1, 5, 4,   1, 0, 0, 0, 1, 0, 4);
    add(0, 0, 0, 1, 5, 5,   0, 0, 0, 0, 1, 0, 5);
    add(0, 0, 0, 1, 5, 5,   0, 0, 1, 2, 1, 0, 5);
    // resume: breakpointed instruction runs once, then hits again on return to 5
    add(0, 1, 1, 1, 5, 5,   0, 0, 1, 2, 1, 0, 5);
    add(0, 0, 0, 1, 5, 5,   1, 0, 0, 2, 1, 0, 5);
    add(0, 0, 0, 1, 5, 6,   1, 0, 0, 2, 1, 0, 6);
    add(0, 0, 0, 1, 5, 5,   0, 0, 0, 2, 1, 0, 7);
    add(0, 0, 0, 1, 5, 5,   0, 0, 1, 2, 1, 0, 7);
    // HALT command coinciding with a breakpoint match
    add(0, 1, 1, 1, 5, 5,   0, 0, 1, 2, 1, 0, 7);
    add(0, 0, 0, 1, 5, 6,   1, 0, 0, 2, 1, 0, 7);
    add(0, 1, 0, 1, 5, 5,   0, 0, 0, 2, 1, 0, 8);
    add(0, 0, 0, 1, 5, 5,   0, 0, 1, 1, 1, 0, 8);
    // RESET_CORE during RUN
    add(0, 1, 1, 0, 0, 0,   0, 0, 1, 1, 1, 0, 8);
    add(0, 0, 0, 0, 0, 1,   1, 0, 0, 1, 1, 0, 8);
    add(0, 1, 3, 0, 0, 2,   1, 0, 0, 1, 1, 0, 9);
    add(0, 0, 0, 0, 0, 2,   0, 1, 0, 1, 0, 0, 0);
    add(0, 1, 1, 0, 0, 2,   0, 1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 2,   0, 1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 2,   0, 1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 2,   0, 0, 1, 0, 1, 0, 0);

    repeat (2) @(negedge clk);
    model_reset();

    foreach (vecs[i]) begin
      rst = vecs[i].r; cmd_valid = vecs[i].cv; cmd = vecs[i].c;
      bp_en = vecs[i].be; bp_addr = vecs[i].ba; pc = vecs[i].p;
      #1;
      chk($sformatf("row%0d core_en", i), 32'(core_en), 32'(vecs[i].en));
      chk($sformatf("row%0d core_rst", i), 32'(core_rst), 32'(vecs[i].crst));
      chk($sformatf("row%0d halted", i), 32'(halted), 32'(vecs[i].h));
      chk($sformatf("row%0d halt_cause", i), 32'(halt_cause), 32'(vecs[i].cause));
      chk($sformatf("row%0d cmd_ready", i), 32'(cmd_ready), 32'(vecs[i].rdy));
      chk($sformatf("row%0d step_done", i), 32'(step_done), 32'(vecs[i].sd));
      chk($sformatf("row%0d retired", i), retired, vecs[i].ret);
      model_step();
      @(negedge clk);
    end

    // saturation of retired near the top of its range
    force dut.retired_q = 32'hFFFF_FFFE;
    #1;
    release dut.retired_q;
    m_ret = 64'hFFFF_FFFE;
    cycle("sat_cmd", 0, 1, 2'b01, 0, 0, 0);
    cycle("sat_run0", 0, 0, 2'b00, 0, 0, 1);
    cycle("sat_run1", 0, 0, 2'b00, 0, 0, 2);
    cycle("sat_run2", 0, 0, 2'b00, 0, 0, 3);
    #1;
    chk("retired_saturated", retired, 32'hFFFF_FFFF);
    chk("still_running", 32'(core_en), 32'd1);

    // synchronous reset while running
    rst = 1'b1; cmd_valid = 1'b0;
    #1;
    model_step();
    @(posedge clk);
    #1;
    chk("midrun_rst halted", 32'(halted), 32'd1);
    chk("midrun_rst halt_cause", 32'(halt_cause), 32'd0);
    chk("midrun_rst core_en", 32'(core_en), 32'd0);
    chk("midrun_rst core_rst", 32'(core_rst), 32'd1);
    chk("midrun_rst cmd_ready", 32'(cmd_ready), 32'd0);
    chk("midrun_rst step_done", 32'(step_done), 32'd0);
    chk("midrun_rst retired", retired, 32'd0);
    @(negedge clk);

    // randomized commands against the model
    for (int i = 0; i < 600; i++) begin
      cycle($sformatf("rand%0d", i),
            logic'($urandom_range(0, 59) == 0),
            logic'($urandom_range(0, 2) != 0),
            2'($urandom_range(0, 3)),
            logic'($urandom_range(0, 1)),
            8'($urandom_range(0, 7)),
            8'($urandom_range(0, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
